// File: rtl/controlador_varredura_display.sv
// rtl/controlador_varredura_display.sv - scan controller for 3-digit 7-segment display and 7x5 LED matrix
module controlador_varredura_display #(
  parameter int DIV_VARREDURA = 50000,
  parameter int BLANK_CICLOS  = 4,
  parameter int NUM_DIGITOS   = 3,
  parameter int NUM_LINHAS    = 7,
  parameter int FRAMES_PISCA  = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] sel_digito,
  output logic       digito_en,
  output logic [2:0] sel_linha,
  output logic [6:0] linha_ativa,
  output logic       sel_matriz,
  output logic       pisca,
  output logic       frame_done
);

  localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
  localparam int BW = (BLANK_CICLOS > 1) ? $clog2(BLANK_CICLOS) : 1;
  localparam int FW = (FRAMES_PISCA > 1) ? $clog2(FRAMES_PISCA) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV_VARREDURA - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLANK_CICLOS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(FRAMES_PISCA - 1);
  localparam logic [1:0]    DIG_MAX = 2'(NUM_DIGITOS - 1);
  localparam logic [2:0]    LIN_MAX = 3'(NUM_LINHAS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } estado_t;

  estado_t        estado, estado_prox;
  logic [PW-1:0]  prescaler, prescaler_prox;
  logic [BW-1:0]  blank_cnt, blank_cnt_prox;
  logic [FW-1:0]  frame_cnt, frame_cnt_prox;
  logic [1:0]     sel_digito_prox;
  logic [2:0]     sel_linha_prox;
  logic [6:0]     linha_ativa_prox;
  logic           digito_en_prox;
  logic           sel_matriz_prox;
  logic           pisca_prox;
  logic           frame_done_prox;
  logic           tick;

  // Step timing: one tick every DIV_VARREDURA enabled cycles.
  assign tick = en && (prescaler == PRE_MAX);

  // Next-state logic: prescaler, blank/show sequencing, selects, frame and blink bookkeeping.
  // Drive outputs are computed from the next state so that they line up with the registered selects.
  always_comb begin
    estado_prox      = estado;
    prescaler_prox   = prescaler;
    blank_cnt_prox   = blank_cnt;
    frame_cnt_prox   = frame_cnt;
    sel_digito_prox  = sel_digito;
    sel_linha_prox   = sel_linha;
    sel_matriz_prox  = sel_matriz;
    pisca_prox       = pisca;
    digito_en_prox   = 1'b0;
    linha_ativa_prox = 7'd0;
    frame_done_prox  = 1'b0;

    if (en) begin
      if (tick) begin
        // A new step always starts blanked, even if the previous one never left BLANK.
        prescaler_prox  = '0;
        estado_prox     = ST_BLANK;
        blank_cnt_prox  = '0;
        sel_digito_prox = (sel_digito == DIG_MAX) ? 2'd0 : sel_digito + 2'd1;
        sel_linha_prox  = (sel_linha == LIN_MAX) ? 3'd0 : sel_linha + 3'd1;
        if (sel_linha == LIN_MAX) begin
          frame_done_prox = 1'b1;
          sel_matriz_prox = ~sel_matriz;
          if (frame_cnt == FRM_MAX) begin
            frame_cnt_prox = '0;
            pisca_prox     = ~pisca;
          end else begin
            frame_cnt_prox = frame_cnt + 1'b1;
          end
        end
      end else begin
        prescaler_prox = prescaler + 1'b1;
        case (estado)
          ST_BLANK: begin
            if (blank_cnt == BLK_MAX) begin
              estado_prox    = ST_SHOW;
              blank_cnt_prox = '0;
            end else begin
              blank_cnt_prox = blank_cnt + 1'b1;
            end
          end
          ST_SHOW: begin
            estado_prox = ST_SHOW;
          end
          default: begin
            estado_prox = ST_BLANK;
          end
        endcase
      end

      if (estado_prox == ST_SHOW) begin
        digito_en_prox   = 1'b1;
        linha_ativa_prox = 7'd1 << sel_linha_prox;
      end
    end
  end

  // State and output registers; clr returns everything to the start of digit 0, row 0, BLANK.
  always_ff @(posedge clk) begin
    if (clr) begin
      estado      <= ST_BLANK;
      prescaler   <= '0;
      blank_cnt   <= '0;
      frame_cnt   <= '0;
      sel_digito  <= 2'd0;
      sel_linha   <= 3'd0;
      sel_matriz  <= 1'b0;
      pisca       <= 1'b0;
      digito_en   <= 1'b0;
      linha_ativa <= 7'd0;
      frame_done  <= 1'b0;
    end else begin
      estado      <= estado_prox;
      prescaler   <= prescaler_prox;
      blank_cnt   <= blank_cnt_prox;
      frame_cnt   <= frame_cnt_prox;
      sel_digito  <= sel_digito_prox;
      sel_linha   <= sel_linha_prox;
      sel_matriz  <= sel_matriz_prox;
      pisca       <= pisca_prox;
      digito_en   <= digito_en_prox;
      linha_ativa <= linha_ativa_prox;
      frame_done  <= frame_done_prox;
    end
  end

endmodule

// File: tb/tb_controlador_varredura_display.sv
// tb/tb_controlador_varredura_display.sv - self-checking bench for controlador_varredura_display
module tb_controlador_varredura_display;

  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FRM = 2;
  localparam int ND  = 3;
  localparam int NL  = 7;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel_digito;
  logic       digito_en;
  logic [2:0] sel_linha;
  logic [6:0] linha_ativa;
  logic       sel_matriz;
  logic       pisca;
  logic       frame_done;

  logic [15:0] obs;
  logic [15:0] exp_v;
  logic [15:0] sb_q[$];
  int total = 0;
  int bad   = 0;
  int m_n   = 0;

  controlador_varredura_display #(
    .DIV_VARREDURA(DIV),
    .BLANK_CICLOS (BLK),
    .NUM_DIGITOS  (ND),
    .NUM_LINHAS   (NL),
    .FRAMES_PISCA (FRM)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .sel_digito (sel_digito),
    .digito_en  (digito_en),
    .sel_linha  (sel_linha),
    .linha_ativa(linha_ativa),
    .sel_matriz (sel_matriz),
    .pisca      (pisca),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {sel_digito, digito_en, sel_linha, linha_ativa, sel_matriz, pisca, frame_done};

  // Expected outputs after the n-th enabled edge since reset, derived arithmetically.
  function automatic logic [15:0] model(input int n, input bit e);
    int s;
    int p;
    logic [1:0] d;
    logic [2:0] l;
    logic       de;
    logic [6:0] la;
    logic       fd;
    logic       sm;
    logic       pk;
    s  = n / DIV;
    p  = n % DIV;
    d  = 2'(s % ND);
    l  = 3'(s % NL);
    de = e && (p >= BLK);
    la = de ? (7'd1 << l) : 7'd0;
    fd = e && (n > 0) && (p == 0) && ((s % NL) == 0);
    sm = 1'((s / NL) % 2);
    pk = 1'(((s / NL) / FRM) % 2);
    return {d, de, l, la, sm, pk, fd};
  endfunction

  task automatic step(input logic c, input logic e);
    clr = c;
    en  = e;
    if (c) m_n = 0;
    else if (e) m_n++;
    sb_q.push_back(c ? 16'h0 : model(m_n, e));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset_sb cyc=%0d got=%h want=%h", i, obs, exp_v);
      end
      total++;
      if (obs !== 16'h0) begin
        bad++;
        $display("FAIL reset_zero cyc=%0d got=%h want=0000", i, obs);
      end
    end
  endtask

  task automatic test_first_step();
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL first_sb edge=%0d got=%h want=%h", k, obs, exp_v);
      end
      if (k == 1) begin
        total++;
        if (digito_en !== 1'b0) begin
          bad++;
          $display("FAIL first_blank edge=1 digito_en got=%b want=0", digito_en);
        end
      end
      if (k >= 2 && k <= 7) begin
        total++;
        if (digito_en !== 1'b1 || linha_ativa !== 7'b0000001) begin
          bad++;
          $display("FAIL first_show edge=%0d en=%b linha=%b want 1/0000001", k, digito_en, linha_ativa);
        end
      end
      if (k == 8) begin
        total++;
        if (sel_digito !== 2'd1 || sel_linha !== 3'd1 || digito_en !== 1'b0) begin
          bad++;
          $display("FAIL first_tick dig=%0d lin=%0d en=%b want 1/1/0", sel_digito, sel_linha, digito_en);
        end
      end
      if (k == 10) begin
        total++;
        if (digito_en !== 1'b1 || linha_ativa !== 7'b0000010) begin
          bad++;
          $display("FAIL second_show en=%b linha=%b want 1/0000010", digito_en, linha_ativa);
        end
      end
    end
  endtask

  task automatic test_digit_wrap();
    step(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wrap_sb edge=%0d got=%h want=%h", k, obs, exp_v);
      end
      total++;
      if (sel_digito === 2'd3) begin
        bad++;
        $display("FAIL digit_three edge=%0d got=%0d want<3", k, sel_digito);
      end
      if (k == 8 || k == 16 || k == 24) begin
        total++;
        if (sel_digito !== 2'((k / 8) % 3)) begin
          bad++;
          $display("FAIL digit_wrap edge=%0d got=%0d want=%0d", k, sel_digito, (k / 8) % 3);
        end
      end
    end
  endtask

  task automatic test_frame_blink();
    step(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    for (int k = 1; k <= 230; k++) begin
      step(1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL frame_sb edge=%0d got=%h want=%h", k, obs, exp_v);
      end
      if (k < 112) begin
        total++;
        if (pisca !== 1'b0) begin
          bad++;
          $display("FAIL pisca_early edge=%0d got=%b want=0", k, pisca);
        end
      end
      if (k == 56) begin
        total++;
        if (sel_linha !== 3'd0 || frame_done !== 1'b1 || sel_matriz !== 1'b1) begin
          bad++;
          $display("FAIL frame_end lin=%0d fd=%b mat=%b want 0/1/1", sel_linha, frame_done, sel_matriz);
        end
      end
      if (k == 57) begin
        total++;
        if (frame_done !== 1'b0) begin
          bad++;
          $display("FAIL frame_pulse got=%b want=0", frame_done);
        end
      end
      if (k == 112) begin
        total++;
        if (sel_matriz !== 1'b0 || pisca !== 1'b1) begin
          bad++;
          $display("FAIL blink_on mat=%b pisca=%b want 0/1", sel_matriz, pisca);
        end
      end
      if (k == 224) begin
        total++;
        if (pisca !== 1'b0) begin
          bad++;
          $display("FAIL blink_off pisca=%b want=0", pisca);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic e;
    step(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    for (int r = 1; r <= 40; r++) begin
      e = !(r >= 20 && r <= 29);
      step(1'b0, e);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL pause_sb raw=%0d got=%h want=%h", r, obs, exp_v);
      end
      if (!e) begin
        total++;
        if (digito_en !== 1'b0 || linha_ativa !== 7'd0 || sel_digito !== 2'd2 || sel_linha !== 3'd2) begin
          bad++;
          $display("FAIL pause_hold raw=%0d en=%b linha=%b dig=%0d lin=%0d want 0/0/2/2",
                   r, digito_en, linha_ativa, sel_digito, sel_linha);
        end
      end
      if (r == 33) begin
        total++;
        if (sel_digito !== 2'd2) begin
          bad++;
          $display("FAIL pause_late raw=33 dig=%0d want=2", sel_digito);
        end
      end
      if (r == 34) begin
        total++;
        if (sel_digito !== 2'd0 || sel_linha !== 3'd3) begin
          bad++;
          $display("FAIL pause_tick raw=34 dig=%0d lin=%0d want 0/3", sel_digito, sel_linha);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    for (int r = 1; r <= 25; r++) begin
      step((r == 13) ? 1'b1 : 1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL midrst_sb raw=%0d got=%h want=%h", r, obs, exp_v);
      end
      if (r == 12) begin
        total++;
        if (sel_digito !== 2'd1 || digito_en !== 1'b1) begin
          bad++;
          $display("FAIL midrst_pre dig=%0d en=%b want 1/1", sel_digito, digito_en);
        end
      end
      if (r == 13) begin
        total++;
        if (obs !== 16'h0) begin
          bad++;
          $display("FAIL midrst_clear got=%h want=0000", obs);
        end
      end
      if (r == 14) begin
        total++;
        if (digito_en !== 1'b0) begin
          bad++;
          $display("FAIL midrst_blank en=%b want=0", digito_en);
        end
      end
      if (r == 15) begin
        total++;
        if (digito_en !== 1'b1 || linha_ativa !== 7'b0000001) begin
          bad++;
          $display("FAIL midrst_show en=%b linha=%b want 1/0000001", digito_en, linha_ativa);
        end
      end
      if (r == 21) begin
        total++;
        if (sel_digito !== 2'd1 || sel_linha !== 3'd1) begin
          bad++;
          $display("FAIL midrst_tick dig=%0d lin=%0d want 1/1", sel_digito, sel_linha);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_digit_wrap();
    test_frame_blink();
    test_pause();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
